// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: keeps the last TAPS 16-bit samples and streams them newest-to-oldest to the MAC, sign-extended to N bits.
// Latency: tap 0 appears one cycle after the input accept; best case one sample per TAPS+1 cycles.
// Backpressure: taps hold while out_ready is low; in_ready is low for the whole frame. Optional clear port: FIR_TAP_SEQ_CLEAR_EN.
module fir_tap_sequencer #(
  parameter int N    = 32,
  parameter int TAPS = 16,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [15:0]   in_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [AW-1:0]        out_tap,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy
`ifdef FIR_TAP_SEQ_CLEAR_EN
  ,
  input  logic                 clear
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [N-1:0]      out_data_q, out_data_d;
  logic [AW-1:0]     out_tap_q, out_tap_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic signed [15:0] hist_q [TAPS];
  logic              hist_we;
  logic              clear_w;
  logic [AW-1:0]     rd_nxt, cnt_inc, wr_inc;

`ifdef FIR_TAP_SEQ_CLEAR_EN
  assign clear_w = clear;
`else
  assign clear_w = 1'b0;
`endif

  // in_ready is deliberately not gated by clear: a cleared sample is dropped, not refused
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tap   = out_tap_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == STREAM);

  assign rd_nxt  = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
  assign wr_inc  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tap_d   = out_tap_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    hist_we     = 1'b0;
    if (clear_w) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // The written sample is not yet in hist_q, so tap 0 comes straight from the input
            hist_we     = 1'b1;
            rd_ptr_d    = wr_ptr_q;
            cnt_d       = '0;
            state_d     = STREAM;
            out_valid_d = 1'b1;
            out_data_d  = N'(in_sample);
            out_tap_d   = '0;
            out_first_d = 1'b1;
            out_last_d  = 1'b0;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (cnt_q == LAST) begin
              state_d     = IDLE;
              wr_ptr_d    = wr_inc;
              out_valid_d = 1'b0;
              out_first_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              cnt_d       = cnt_inc;
              rd_ptr_d    = rd_nxt;
              out_data_d  = N'(hist_q[rd_nxt]);
              out_tap_d   = cnt_inc;
              out_first_d = 1'b0;
              out_last_d  = (cnt_inc == LAST);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tap_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tap_q   <= out_tap_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      if (clear_w) begin
        for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
      end else if (hist_we) begin
        hist_q[wr_ptr_q] <= in_sample;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer (TAPS=4, N=32): a shift-history model queues expected taps, a negedge monitor checks them.
module tb_fir_tap_sequencer;
  localparam int N    = 32;
  localparam int TAPS = 4;
  localparam int AWT  = $clog2(TAPS);

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_sample;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_data;
  logic [AWT-1:0]     out_tap;
  logic               out_first;
  logic               out_last;
  logic               busy;
  logic               clear;

  typedef struct packed {
    logic [N-1:0]   d;
    logic [AWT-1:0] t;
    logic           f;
    logic           l;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [15:0] mh[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 busy_cnt = 0;
  bit                 rand_mode = 0;
  bit                 rst_prev = 0;
  bit                 clr_prev = 0;
  bit                 pend = 0;

  fir_tap_sequencer #(.N(N), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tap(out_tap), .out_first(out_first), .out_last(out_last),
    .busy(busy)
`ifdef FIR_TAP_SEQ_CLEAR_EN
    , .clear(clear)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] sext(input logic [15:0] s);
    return {{(N-16){s[15]}}, s};
  endfunction

  task automatic model_reset();
    mh.delete();
    for (int i = 0; i < TAPS; i++) mh.push_back(16'sd0);
    exp_q.delete();
  endtask

  task automatic model_accept(input logic signed [15:0] s);
    exp_t e;
    mh.push_front(s);
    void'(mh.pop_back());
    for (int k = 0; k < TAPS; k++) begin
      e.d = sext(mh[k]);
      e.t = AWT'(k);
      e.f = (k == 0);
      e.l = (k == TAPS - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs and handshakes are observed mid-cycle, ahead of the edge that commits them
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check(in_ready == 1'b0, "in_ready_during_reset", 64'(in_ready), 64'd0);
      model_reset();
      rst_prev = 1;
      pend = 0;
    end else begin
      if (rst_prev)
        check({out_valid, out_data, out_tap, out_first, out_last, busy, in_ready} == {1'b0, {N{1'b0}}, {AWT{1'b0}}, 4'b0001},
              "post_reset_outputs", {out_valid, out_data, out_tap, out_first, out_last, busy, in_ready},
              {1'b0, {N{1'b0}}, {AWT{1'b0}}, 4'b0001});
      rst_prev = 0;
      if (clr_prev) check(out_valid == 1'b0, "out_valid_after_clear", 64'(out_valid), 64'd0);
      if (pend) check(out_valid && out_first && out_tap == '0, "tap0_latency", {out_valid, out_first, out_tap}, {2'b11, {AWT{1'b0}}});
      pend = 0;
      check(busy == out_valid, "busy_vs_out_valid", 64'(busy), 64'(out_valid));
      check(in_ready == !busy, "in_ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (busy) busy_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_tap", {out_data, out_tap}, 64'd0);
        end else begin
          e = exp_q[0];
          check({out_data, out_tap, out_first, out_last} == e, "tap_value", {out_data, out_tap, out_first, out_last}, e);
        end
      end
      if (clear) begin
        if (!busy) check(in_ready == 1'b1, "in_ready_during_clear", 64'(in_ready), 64'd1);
        model_reset();
        clr_prev = 1;
      end else begin
        clr_prev = 0;
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          model_accept(in_sample);
          pend = 1;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic push(input logic [15:0] s);
    int n = 0;
    in_sample = s;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check(1'b0, "push_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sample = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) check(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    clear     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single sample after reset: 100,0,0,0 and busy for exactly TAPS cycles
    busy_cnt = 0;
    push(16'sd100);
    drain();
    check(busy_cnt == TAPS, "busy_cycles", 64'(busy_cnt), 64'(TAPS));

    // Pointer wrap: the frame for 5 is 5,4,3,2; pushes held across frames
    for (int i = 1; i <= 5; i++) push(16'(i));
    drain();

    // Sign-extension extremes
    push(16'sh8000);
    push(16'sh7FFF);
    drain();

    // Random samples under random backpressure
    rand_mode = 1;
    for (int i = 0; i < 30; i++) begin
      push(16'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    drain();
    rand_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame at tap 2, then history must read back as zeros
    push(16'sd11);
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_tap == AWT'(1)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(out_valid && out_tap == AWT'(1))) check(1'b0, "wait_tap1_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(16'sd7);
    drain();

`ifdef FIR_TAP_SEQ_CLEAR_EN
    // Clear wins over a same-cycle sample; next frame sees zeroed history
    for (int i = 1; i <= 4; i++) push(16'(i));
    drain();
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'sd55;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    push(16'sd9);
    drain();
`endif

    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Input-side front end of the FIR datapath, mirroring the output saturator: accepts 16-bit signed samples and widens them to N bits; the saturator narrows N-bit results back to 16 bits.
- Keeps a circular history of the last TAPS samples.
- For each accepted sample, streams the history newest-to-oldest to the MAC, one sign-extended tap per handshake, with tap index and first/last framing.

Parameters:
N, 32, output data width; sign-extension target; must be >= 16
TAPS, 16, history depth and number of taps streamed per input sample; >= 2, need not be a power of two
AW, $clog2(TAPS), width of the tap index and pointers (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_sample is valid
in_ready  output  1  block can accept a sample
in_sample  input  16  signed input sample
out_valid  output  1  out_data/out_tap/out_first/out_last are valid
out_ready  input  1  MAC accepts the current tap
out_data  output  N  history sample, sign-extended to N bits
out_tap  output  AW  tap index, 0 = newest sample
out_first  output  1  high with tap 0
out_last  output  1  high with tap TAPS-1
busy  output  1  high while in the STREAM state

Behaviour:
- Reset (rst_n low at a clk edge):
  - State IDLE, wr_ptr=0, rd_ptr=0, tap count=0.
  - All TAPS history entries cleared to 0.
  - Outputs: in_ready=0 during the reset cycle, then 1 in IDLE; out_valid=0, out_data=0, out_tap=0, out_first=0, out_last=0, busy=0.
  - Reset mid-stream abandons the frame with no further taps emitted.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at edge t: write in_sample to hist[wr_ptr], set rd_ptr=wr_ptr, load tap 0 into the output register, go to STREAM.
- STREAM:
  - in_ready=0, busy=1, out_valid=1.
  - Tap 0 is presented at cycle t+1 (1-cycle latency, registered outputs).
  - out_data = {{(N-16){hist[rd_ptr][15]}}, hist[rd_ptr]}; out_tap = count.
  - On out_valid&&out_ready:
    - If count < TAPS-1: count++, rd_ptr decrements (0 wraps to TAPS-1), next tap is registered for the following cycle.
    - If count == TAPS-1: out_last is asserted with this tap; on its acceptance go to IDLE, wr_ptr increments (TAPS-1 wraps to 0), out_valid drops next cycle.
- Backpressure: while out_valid && !out_ready, all outputs hold stable; no pointer moves.
- Input handshake is only possible in IDLE; no sample overlaps a frame.
  - in_valid held during STREAM is accepted in the first IDLE cycle after the frame.
- Max throughput: one sample per TAPS+1 cycles with out_ready tied high.
- Before TAPS samples have been seen, older taps read the reset zeros.
- Sign extension is exact: no rounding or saturation in this block.
- in_sample is ignored whenever in_ready=0.

Optional Feature:
- Macro FIR_TAP_SEQ_CLEAR_EN.
- Defined:
  - Adds input port clear (1 bit, synchronous, active-high), effective in any state.
  - Zeros all history and wr_ptr, forces IDLE, drops out_valid next cycle.
  - rst_n has priority.
  - clear has priority over a same-cycle input handshake; the sample is dropped and in_ready stays high.
- Not defined: port absent; history is cleared only by rst_n.

Test Plan:
1. Reset, TAPS=4, out_ready=1, push 16'sd100 -> taps 0..3 = 100,0,0,0 (N=32); out_first on tap 0, out_last on tap 3; busy for 4 cycles; tap 0 appears 1 cycle after the accept.
2. Push 1,2,3,4,5 (TAPS=4) -> frame for 5 = 5,4,3,2; checks wr_ptr/rd_ptr wrap.
3. Push 16'sh8000 and 16'sh7FFF -> out_data 32'hFFFF8000 and 32'h00007FFF; checks sign extension.
4. Random out_ready stalls of 0-3 cycles -> outputs stable during stalls; exactly TAPS taps per frame, in order; in_ready=0 throughout STREAM.
5. rst_n low for 1 cycle at tap 2 -> out_valid=0 next cycle; next sample 7 gives frame 7,0,0,0.
6. With FIR_TAP_SEQ_CLEAR_EN: clear pulsed with in_valid in IDLE after history 1..4 -> sample dropped; next push 9 gives frame 9,0,0,0.
